// File: rtl/vote_pkg.sv
// Shared types, segment constants and helpers for the vote tally display.
// Segment codes are {a,b,c,d,e,f,g}, active-high.
package vote_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t       BCD_MAX_DIGIT = 4'd9;
    localparam logic [6:0] SEG_BLANK     = 7'b000_0000;
    localparam logic [6:0] SEG_ZERO      = 7'b111_1110;

    function automatic logic [6:0] bcd_to_seg7(input bcd_t d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'b111_1110;
            4'd1:    seg = 7'b011_0000;
            4'd2:    seg = 7'b110_1101;
            4'd3:    seg = 7'b111_1001;
            4'd4:    seg = 7'b011_0011;
            4'd5:    seg = 7'b101_1011;
            4'd6:    seg = 7'b101_1111;
            4'd7:    seg = 7'b111_0000;
            4'd8:    seg = 7'b111_1111;
            4'd9:    seg = 7'b111_1011;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // A counter is at its maximum count when every digit reads 9.
    function automatic logic digit_is_max(input bcd_t d);
        return d == BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_sat_counter.sv
// Multi-digit BCD counter that saturates at all-nines instead of wrapping.
module bcd_sat_counter
    import vote_pkg::*;
#(
    parameter int unsigned DIGITS = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_inc,
    input  logic              i_clr,
    output bcd_t [DIGITS-1:0] o_digits,
    output logic              o_at_max
);

    bcd_t [DIGITS-1:0] r_digits;
    bcd_t [DIGITS-1:0] w_next;
    logic [DIGITS-1:0] w_nines;

    always_comb begin
        logic carry;
        carry   = 1'b1;
        w_next  = r_digits;
        w_nines = '0;
        for (int k = 0; k < DIGITS; k++) begin
            w_nines[k] = digit_is_max(r_digits[k]);
            if (carry) begin
                if (w_nines[k]) begin
                    w_next[k] = '0;
                end else begin
                    w_next[k] = r_digits[k] + 4'd1;
                    carry     = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_digits <= '0;
        end else if (i_inc && !o_at_max) begin
            r_digits <= w_next;
        end
    end

    assign o_digits = r_digits;
    assign o_at_max = &w_nines;

endmodule

// File: rtl/vote_tally_display.sv
// N-channel saturating BCD vote tally with a registered 7-segment view of one
// candidate, picked by an auto-scan timer or a manual select.
module vote_tally_display
    import vote_pkg::*;
#(
    parameter int unsigned NUM_CAND = 4,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned SCAN_DIV = 50000,
    localparam int unsigned CW      = $clog2(NUM_CAND)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NUM_CAND-1:0]   i_vote_req,
    input  logic                  i_lock,
    input  logic                  i_clear,
    input  logic                  i_manual,
    input  logic [CW-1:0]         i_sel_cand,
    output logic [DIGITS*7-1:0]   o_seg,
    output logic [CW-1:0]         o_cand_id,
    output logic                  o_vote_ack,
    output logic                  o_vote_err,
    output logic [NUM_CAND-1:0]   o_ovf
);

    localparam int unsigned SW = $clog2(SCAN_DIV);

    logic [NUM_CAND-1:0] r_vote_req_q;
    logic [NUM_CAND-1:0] r_ovf;
    logic [CW-1:0]       r_cand_id;
    logic [SW-1:0]       r_scan;
    logic [DIGITS*7-1:0] r_seg;
    logic                r_ack;
    logic                r_err;

    logic [NUM_CAND-1:0] w_rise;
    logic [NUM_CAND-1:0] w_at_max;
    logic [NUM_CAND-1:0] w_inc;
    logic                w_one_hot;
    logic                w_multi;
    logic                w_open;
    logic                w_hit_max;
    logic                w_sel_valid;
    logic [DIGITS*7-1:0] w_seg_d;
    bcd_t [DIGITS-1:0]   w_digits [NUM_CAND];

    assign w_rise      = i_vote_req & ~r_vote_req_q;
    assign w_one_hot   = $onehot(w_rise);
    assign w_multi     = (w_rise != '0) && !w_one_hot;
    assign w_open      = !i_clear && !i_lock;
    assign w_hit_max   = |(w_rise & w_at_max);
    assign w_inc       = (w_open && w_one_hot) ? w_rise : '0;
    assign w_sel_valid = {1'b0, i_sel_cand} < (CW+1)'(NUM_CAND);

    for (genvar i = 0; i < NUM_CAND; i++) begin : g_cand
        bcd_sat_counter #(
            .DIGITS (DIGITS)
        ) u_counter (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_inc    (w_inc[i]),
            .i_clr    (i_clear),
            .o_digits (w_digits[i]),
            .o_at_max (w_at_max[i])
        );
    end

    // An out-of-range manual selection blanks the display rather than aliasing.
    always_comb begin
        w_seg_d = '0;
        if (!(i_manual && !w_sel_valid)) begin
            for (int k = 0; k < DIGITS; k++) begin
                w_seg_d[7*k +: 7] = bcd_to_seg7(w_digits[r_cand_id][k]);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vote_req_q <= '0;
            r_ovf        <= '0;
            r_ack        <= 1'b0;
            r_err        <= 1'b0;
            r_cand_id    <= '0;
            r_scan       <= '0;
            r_seg        <= {DIGITS{SEG_ZERO}};
        end else begin
            r_vote_req_q <= i_vote_req;
            r_ack        <= w_open && w_one_hot && !w_hit_max;
            r_err        <= w_open && (w_multi || (w_one_hot && w_hit_max));
            r_seg        <= w_seg_d;
            if (i_clear) begin
                r_ovf <= '0;
            end else if (w_open && w_one_hot) begin
                r_ovf <= r_ovf | (w_rise & w_at_max);
            end
            // Holding the scan timer at 0 in manual mode restarts it on return to auto.
            if (i_manual) begin
                r_scan <= '0;
                if (w_sel_valid) begin
                    r_cand_id <= i_sel_cand;
                end
            end else if (r_scan == SW'(SCAN_DIV - 1)) begin
                r_scan    <= '0;
                r_cand_id <= (r_cand_id == CW'(NUM_CAND - 1)) ? '0 : r_cand_id + 1'b1;
            end else begin
                r_scan <= r_scan + 1'b1;
            end
        end
    end

    assign o_seg      = r_seg;
    assign o_cand_id  = r_cand_id;
    assign o_vote_ack = r_ack;
    assign o_vote_err = r_err;
    assign o_ovf      = r_ovf;

endmodule
